sr_latch_ctrl: RTL
==================

# sr_latch_ctrl

Sequencing controller for a bank of N cross-coupled SR latches. Accepts per-latch set/clear requests, arbitrates round-robin, and drives each latch's s/r inputs with clean, width-controlled pulses. Never asserts s and r together, and holds both low for a recovery gap between operations. Sits between software-style requesters and the latch array, and reads back latch outputs to verify every operation.

## Interface
- N, default 4: number of latches controlled.
- PULSE_CYC, default 2: s/r pulse width in cycles; must be ≥1.
- GAP_CYC, default 1: all-low recovery cycles after a pulse; 0 skips the GAP state.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_set  in  N  level request to set latch i; held until ack[i].
- req_clr  in  N  level request to clear latch i; held until ack[i].
- q_in  in  N  latch q outputs, fed back for skip and verify.
- lat_s  out  N  set drive to latch i.
- lat_r  out  N  reset drive to latch i.
- ack  out  N  one-cycle completion pulse for latch i.
- busy  out  1  high in every state except IDLE.
- err_conflict  out  1  one-cycle pulse when a granted index had both req_set and req_clr high.
- err_verify  out  1  one-cycle pulse when q_in disagrees with the expected value at ACK.

## Operation
- States: IDLE, PULSE, GAP, ACK. The state enum and operation type {OP_SET, OP_CLR} are registered.
- **IDLE:**
  - pending[i] = req_set[i] | req_clr[i].
  - If any index is pending, grant the first pending index at or after rr_ptr, with wrap-around.
  - Latch idx and op into registers.
  - Set rr_ptr to idx+1 mod N.
- **Conflict:** if both req_set[idx] and req_clr[idx] are high, op=OP_CLR (clear wins) and err_conflict pulses in the grant cycle.
- **Skip:** if q_in[idx] already equals the target (1 for SET, 0 for CLR), go straight to ACK with no pulse.
- **No skip:** go to PULSE.
- **PULSE:**
  - Drive lat_s[idx] (SET) or lat_r[idx] (CLR) high for exactly PULSE_CYC cycles. A down-counter is loaded at grant.
  - All other lat bits stay 0.
  - Then go to GAP, or to ACK if GAP_CYC=0.
- **GAP:** all lat_s/lat_r are 0 for GAP_CYC cycles, then go to ACK.
- **ACK:**
  - ack[idx]=1 for one cycle.
  - err_verify=1 if q_in[idx] ≠ target.
  - Return to IDLE.
- **Handshake:** the requester drops req in the cycle after ack. A request still high in the next IDLE is treated as new; it is normally skipped and acked again.
- **Invariant:** lat_s & lat_r == 0 every cycle. At most one bit of lat_s|lat_r is high.
- Requests arriving while busy wait. Request changes during PULSE/GAP do not affect the registered op.

## Timing
- **Reset values:** lat_s=0, lat_r=0, ack=0, busy=0, err_*=0, state=IDLE, rr_ptr=0, counter=0.
- **Normal path:** grant at edge T. Pulse is high for cycles T+1..T+P. Gap covers T+P+1..T+P+G. ack is high in cycle T+P+G+1. The next grant is possible at T+P+G+2.
- **Skip path:** ack is high in cycle T+1, busy for 1 cycle.
- Counter width is $clog2(max(PULSE_CYC,GAP_CYC)+1).
- **Reset mid-operation:** at the next edge all outputs go to 0 and no ack is issued. The latch keeps whatever value it reached.
- **rr_ptr wrap:** rr_ptr wraps from N-1 to 0. A single requester is re-granted whenever it is the only pending index.

## Structure
- Package sr_ctrl_pkg holds:
  - the state_t enum {IDLE, PULSE, GAP, ACK};
  - the op_t enum {OP_SET, OP_CLR};
  - a function returning the target q for an op.
- Sub-module rr_arbiter #(N): inputs pending and rr_ptr; outputs grant_valid and grant_idx. Purely combinational.
- Top level holds the FSM, counter, registered idx/op/ptr, and output decode.

## Test plan
- **Basic set:** after reset with q_in=0000, pulse req_set[2] with P=2, G=1. Required: lat_s=0100 for 2 cycles, then 1 gap cycle, then ack=0100 one cycle later. The bench latch model drives q_in[2]=1, and err_verify stays 0.
- **Skip:** q_in[1]=1, req_set[1]. Required: ack[1] one cycle after grant, no lat_s activity, busy high for 1 cycle.
- **Round-robin:** req_clr=1111 held high and re-raised after each ack, with q_in=1111. Required grant order 0,1,2,3,0. Check ack order and that lat_r is never multi-hot.
- **Conflict:** req_set[3]=req_clr[3]=1 with q_in[3]=1. Required: err_conflict pulse at grant, then lat_r[3] pulse. lat_s is never 1 during this operation; the no-overlap invariant is asserted every cycle.
- **Verify failure:** the latch model is stuck at 0 and req_set[0] is issued. Required: err_verify=1 in the same cycle as ack[0].
- **Reset mid-pulse:** assert rst in the first PULSE cycle. Required: all outputs 0 on the next edge, no ack, rr_ptr=0 afterwards.

Source files
------------

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types for the SR latch sequencing controller.
// FSM state, operation kind and the target q of an operation.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP,
      ACK
   } state_t;

   typedef enum logic {
      OP_SET,
      OP_CLR
   } op_t;

   function automatic logic target_q(input op_t op);
      return (op == OP_SET);
   endfunction

endpackage

// File: rtl/sr_latch_ctrl_arb.sv
// Round-robin arbiter: first pending index at or after rr_ptr.
// Purely combinational; wraps from N-1 back to 0.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [PW-1:0] rr_ptr,
   output logic          grant_valid,
   output logic [PW-1:0] grant_idx
);

   logic [N-1:0] rot;
   int           off;
   int           sum;

   always_comb begin
      // rotate so that bit 0 corresponds to rr_ptr
      rot = N'({pending, pending} >> rr_ptr);
      grant_valid = |pending;
      off = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = k;
      end
      sum = off + int'(rr_ptr);
      if (sum >= N) sum = sum - N;
      grant_idx = PW'(sum);
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a bank of SR latches: arbitrates set/clear requests
// and drives width-controlled, non-overlapping s/r pulses.
module sr_latch_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int N         = 4,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_set,
   input  logic [N-1:0] req_clr,
   input  logic [N-1:0] q_in,
   output logic [N-1:0] lat_s,
   output logic [N-1:0] lat_r,
   output logic [N-1:0] ack,
   output logic         busy,
   output logic         err_conflict,
   output logic         err_verify
);

   localparam int PW   = (N > 1) ? $clog2(N) : 1;
   localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [PW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            conf_q, conf_d;

   logic [N-1:0]    pending;
   logic            gnt_valid;
   logic [PW-1:0]   gnt_idx;
   logic [N-1:0]    sel;

   assign pending = req_set | req_clr;

   rr_arbiter #(
      .N  (N),
      .PW (PW)
   ) u_arb (
      .pending     (pending),
      .rr_ptr      (ptr_q),
      .grant_valid (gnt_valid),
      .grant_idx   (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_SET;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         conf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         conf_q  <= conf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      conf_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               idx_d  = gnt_idx;
               // clear wins when both requests are raised
               op_d   = req_clr[gnt_idx] ? OP_CLR : OP_SET;
               conf_d = req_set[gnt_idx] & req_clr[gnt_idx];
               ptr_d  = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
               if (q_in[gnt_idx] == target_q(op_d)) begin
                  state_d = ACK;
               end else begin
                  state_d = PULSE;
                  cnt_d   = CW'(PULSE_CYC);
               end
            end
         end
         PULSE: begin
            if (cnt_q <= CW'(1)) begin
               if (GAP_CYC == 0) begin
                  state_d = ACK;
                  cnt_d   = '0;
               end else begin
                  state_d = GAP;
                  cnt_d   = CW'(GAP_CYC);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q <= CW'(1)) begin
               state_d = ACK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sel = N'(1) << idx_q;

   assign lat_s = (state_q == PULSE && op_q == OP_SET) ? sel : '0;
   assign lat_r = (state_q == PULSE && op_q == OP_CLR) ? sel : '0;
   assign ack   = (state_q == ACK) ? sel : '0;
   assign busy  = (state_q != IDLE);

   assign err_conflict = conf_q;
   assign err_verify   = (state_q == ACK) &&
                         (q_in[idx_q] != target_q(op_q));

endmodule
